// File: rtl/irq_arbiter_if.sv
// ---------------------------------------------------------------------------
// irq_arbiter_if
// Bundles the software register port and the core-side interrupt handshake
// of irq_arbiter.
//   cfg_we/cfg_addr/cfg_wdata : register write strobe, select, data
//   cfg_rdata                 : combinational read data for cfg_addr
//   irq_req/irq_id            : request to the core and the presented ID
//   irq_ack/irq_done          : core accept pulse / handler-finished pulse
//   irq_active                : a handler is in progress
// slave  : the arbiter side
// master : the core / software side
// ---------------------------------------------------------------------------
interface irq_arbiter_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic [15:0] cfg_rdata;
    logic        irq_req;
    logic [4:0]  irq_id;
    logic        irq_ack;
    logic        irq_done;
    logic        irq_active;

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
        output cfg_rdata, irq_req, irq_id, irq_active
    );

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
        input  cfg_rdata, irq_req, irq_id, irq_active
    );
endinterface

// File: rtl/irq_arbiter.sv
// ---------------------------------------------------------------------------
// irq_arbiter
// Captures rising edges of the external lines and NMI into pending bits,
// masks and prioritises them, and presents one interrupt at a time to the
// core. One level of NMI nesting over an active external handler.
// Ports:
//   HCLK, HRESET        : clock, asynchronous active-high reset
//   NMI                 : non-maskable interrupt, rising-edge sensitive
//   externalInterrupts  : external lines, rising-edge sensitive
//   bus (slave)         : register port and request/ack/done handshake
// Registers: 0 ENABLE, 1 PENDING (write-1-to-clear), 2 STATUS (read-only),
//            3 CTRL (bit 0 = global interrupt enable)
// ---------------------------------------------------------------------------
module irq_arbiter #(
    parameter int unsigned NUM_IRQ = 16
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic               NMI,
    input  logic [NUM_IRQ-1:0] externalInterrupts,
    irq_arbiter_if.slave       bus
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACTIVE,
        NMI_REQ,
        NMI_ACTIVE
    } state_t;

    localparam logic [4:0] NMI_ID = 5'd16;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] ext_prev_q;
    logic               nmi_prev_q;
    logic [NUM_IRQ-1:0] enable_q, enable_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic               nmi_pend_q, nmi_pend_d;
    logic               gie_q, gie_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [4:0]         saved_id_q, saved_id_d;

    logic [NUM_IRQ-1:0] ext_edge;
    logic               nmi_edge;
    logic [NUM_IRQ-1:0] ext_clr;
    logic [NUM_IRQ-1:0] wr_clr;
    logic               nmi_clr;
    logic [NUM_IRQ-1:0] masked;
    logic               cand_valid;
    logic [4:0]         cand_id;
    logic [15:0]        enable_16;
    logic [15:0]        pending_16;
    logic               presented_ok;
    logic               nested;

    assign ext_edge = externalInterrupts & ~ext_prev_q;
    assign nmi_edge = NMI & ~nmi_prev_q;

    // Zero-padded 16-bit views so register reads and per-ID lookups work
    // for any NUM_IRQ up to 16.
    always_comb begin
        enable_16  = '0;
        pending_16 = '0;
        enable_16[NUM_IRQ-1:0]  = enable_q;
        pending_16[NUM_IRQ-1:0] = pending_q;
    end

    // Candidate: pending NMI first, otherwise lowest enabled pending line.
    // The loop runs downward so the lowest index is the last assignment.
    always_comb begin
        cand_valid = 1'b0;
        cand_id    = '0;
        masked     = pending_q & enable_q;
        if (nmi_pend_q) begin
            cand_valid = 1'b1;
            cand_id    = NMI_ID;
        end else if (gie_q) begin
            for (int unsigned i = NUM_IRQ; i > 0; i--) begin
                if (masked[i-1]) begin
                    cand_valid = 1'b1;
                    cand_id    = 5'(i - 1);
                end
            end
        end
    end

    // A presented external request stays valid only while it is enabled.
    assign presented_ok = gie_q && enable_16[irq_id_q[3:0]];

    always_comb begin
        state_d    = state_q;
        irq_id_d   = irq_id_q;
        saved_id_d = saved_id_q;
        ext_clr    = '0;
        nmi_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    irq_id_d = cand_id;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.irq_ack) begin
                    if (irq_id_q[4]) begin
                        nmi_clr = 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
                            ext_clr[i] = (irq_id_q[3:0] == 4'(i));
                        end
                    end
                    state_d = ACTIVE;
                end else if (!irq_id_q[4] && nmi_pend_q) begin
                    // NMI overrides the presented external ID in place.
                    irq_id_d = NMI_ID;
                end else if (!irq_id_q[4] && !presented_ok) begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                // done beats a same-cycle NMI; the NMI is then taken from IDLE.
                if (bus.irq_done) begin
                    state_d = IDLE;
                end else if (!irq_id_q[4] && nmi_pend_q) begin
                    saved_id_d = irq_id_q;
                    irq_id_d   = NMI_ID;
                    state_d    = NMI_REQ;
                end
            end
            NMI_REQ: begin
                if (bus.irq_ack) begin
                    nmi_clr = 1'b1;
                    state_d = NMI_ACTIVE;
                end
            end
            NMI_ACTIVE: begin
                if (bus.irq_done) begin
                    irq_id_d = saved_id_q;
                    state_d  = ACTIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register writes; a new edge wins over any same-cycle clear.
    always_comb begin
        enable_d = enable_q;
        gie_d    = gie_q;
        wr_clr   = '0;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0:    enable_d = bus.cfg_wdata[NUM_IRQ-1:0];
                2'd1:    wr_clr   = bus.cfg_wdata[NUM_IRQ-1:0];
                2'd3:    gie_d    = bus.cfg_wdata[0];
                default: ;
            endcase
        end
        pending_d  = (pending_q & ~(ext_clr | wr_clr)) | ext_edge;
        nmi_pend_d = (nmi_pend_q & ~nmi_clr) | nmi_edge;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q    <= IDLE;
            ext_prev_q <= '0;
            nmi_prev_q <= 1'b0;
            enable_q   <= '0;
            pending_q  <= '0;
            nmi_pend_q <= 1'b0;
            gie_q      <= 1'b0;
            irq_id_q   <= '0;
            saved_id_q <= '0;
        end else begin
            state_q    <= state_d;
            ext_prev_q <= externalInterrupts;
            nmi_prev_q <= NMI;
            enable_q   <= enable_d;
            pending_q  <= pending_d;
            nmi_pend_q <= nmi_pend_d;
            gie_q      <= gie_d;
            irq_id_q   <= irq_id_d;
            saved_id_q <= saved_id_d;
        end
    end

    assign nested = (state_q == NMI_REQ) || (state_q == NMI_ACTIVE);

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = enable_16;
            2'd1:    bus.cfg_rdata = pending_16;
            2'd2:    bus.cfg_rdata = {5'b0, nmi_pend_q, nested, bus.irq_active,
                                      3'b0, irq_id_q};
            default: bus.cfg_rdata = {15'b0, gie_q};
        endcase
    end

    assign bus.irq_req    = (state_q == REQ) || (state_q == NMI_REQ);
    assign bus.irq_active = (state_q == ACTIVE) || nested;
    assign bus.irq_id     = irq_id_q;

endmodule
